exhaustive_sweep_checker: RTL and testbench

//  Self-checking, synthesisable exhaustive stimulus engine for small combinational functions.

---
 rtl/exhaustive_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_exhaustive_sweep_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive stimulus engine with built-in truth-table checking.
// Walks every N_IN-bit vector in ascending order, holds each one for DWELL
// cycles, samples the DUT response on the last dwell cycle and compares it
// against EXP_TT. Reports an error count, the first failing vector and the
// captured truth table.
//
// Control contract: there is no valid/ready handshake here. 'start' is a
// level sampled on every rising edge. It only has an effect in IDLE or DONE,
// and it is ignored while a sweep is running. 'done' and 'pass' are stable
// from the edge that enters DONE until the next accepted start or reset.
module exhaustive_sweep_checker #(
    parameter int                             N_IN    = 4,
    parameter int                             N_OUT   = 1,
    parameter int                             DWELL   = 10,
    parameter logic [(2**N_IN)*N_OUT-1:0]     EXP_TT  = 16'h6996,
    parameter logic [(2**N_IN)-1:0]           DC_MASK = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [N_IN-1:0]               dut_in,
    input  logic [N_OUT-1:0]              dut_out,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [N_IN:0]                 err_cnt,
    output logic                          first_err_valid,
    output logic [N_IN-1:0]               first_err_vec,
    output logic [(2**N_IN)*N_OUT-1:0]    tt_captured,
    output logic [1:0]                    state_dbg
);

    localparam int                TT_W       = (2**N_IN) * N_OUT;
    localparam int                DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N_IN-1:0]   VEC_LAST   = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [N_IN:0]     err_cnt_q, err_cnt_d;
    logic              fev_valid_q, fev_valid_d;
    logic [N_IN-1:0]   fev_vec_q, fev_vec_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [N_OUT-1:0]  exp_val;
    logic              sample_edge;

    // Expected response for the vector currently being driven.
    assign exp_val     = EXP_TT[vec_q*N_OUT +: N_OUT];
    assign sample_edge = (dwell_q == DWELL_LAST);

    // Next-state logic: sweep sequencing, sampling and result accumulation.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        dut_in_d    = dut_in_q;
        err_cnt_d   = err_cnt_q;
        fev_valid_d = fev_valid_q;
        fev_vec_d   = fev_vec_q;
        tt_d        = tt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                dut_in_d = '0;
                if (start) begin
                    // A fresh sweep always starts from a clean result set.
                    state_d     = ST_DRIVE;
                    vec_d       = '0;
                    dwell_d     = '0;
                    err_cnt_d   = '0;
                    fev_valid_d = 1'b0;
                    fev_vec_d   = '0;
                    tt_d        = '0;
                end
            end
            ST_DRIVE: begin
                dwell_d = dwell_q + DW'(1);
                if (sample_edge) begin
                    tt_d[vec_q*N_OUT +: N_OUT] = dut_out;
                    if (!DC_MASK[vec_q] && (dut_out != exp_val)) begin
                        // Cannot overflow: at most 2^N_IN vectors can fail.
                        err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                        if (!fev_valid_q) begin
                            fev_valid_d = 1'b1;
                            fev_vec_d   = vec_q;
                        end
                    end
                    dwell_d = '0;
                    if (vec_q == VEC_LAST) begin
                        state_d  = ST_DONE;
                        dut_in_d = '0;
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        dut_in_d = vec_q + N_IN'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                dut_in_d = '0;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            dwell_q     <= '0;
            dut_in_q    <= '0;
            err_cnt_q   <= '0;
            fev_valid_q <= 1'b0;
            fev_vec_q   <= '0;
            tt_q        <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dwell_q     <= dwell_d;
            dut_in_q    <= dut_in_d;
            err_cnt_q   <= err_cnt_d;
            fev_valid_q <= fev_valid_d;
            fev_vec_q   <= fev_vec_d;
            tt_q        <= tt_d;
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = (state_q == ST_DRIVE);
    assign done            = (state_q == ST_DONE);
    assign pass            = (state_q == ST_DONE) && (err_cnt_q == '0);
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_valid_q;
    assign first_err_vec   = fev_vec_q;
    assign tt_captured     = tt_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Bench for exhaustive_sweep_checker: three instances (default parity/stuck
// target, a don't-care-masked stuck target, and a 2-in/2-out half adder).
module tb_exhaustive_sweep_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // ---------------- main instance (defaults) ----------------
    logic        start_main = 1'b0;
    logic        mode_stuck = 1'b0;
    logic [3:0]  m_in;
    logic        m_out;
    logic        m_busy, m_done, m_pass, m_fev;
    logic [4:0]  m_err;
    logic [3:0]  m_fvec;
    logic [15:0] m_tt;
    logic [1:0]  m_st;

    assign m_out = mode_stuck ? 1'b0 : ^m_in;

    exhaustive_sweep_checker u_main (
        .clk(clk), .rst_n(rst_n), .start(start_main),
        .dut_in(m_in), .dut_out(m_out),
        .busy(m_busy), .done(m_done), .pass(m_pass), .err_cnt(m_err),
        .first_err_valid(m_fev), .first_err_vec(m_fvec),
        .tt_captured(m_tt), .state_dbg(m_st)
    );

    // ---------------- masked instance, always stuck-at-0 ----------------
    logic [3:0]  d_in;
    logic        d_busy, d_done, d_pass, d_fev;
    logic [4:0]  d_err;
    logic [3:0]  d_fvec;
    logic [15:0] d_tt;
    logic [1:0]  d_st;

    exhaustive_sweep_checker #(.DC_MASK(16'h0006)) u_dc (
        .clk(clk), .rst_n(rst_n), .start(start_main),
        .dut_in(d_in), .dut_out(1'b0),
        .busy(d_busy), .done(d_done), .pass(d_pass), .err_cnt(d_err),
        .first_err_valid(d_fev), .first_err_vec(d_fvec),
        .tt_captured(d_tt), .state_dbg(d_st)
    );

    // ---------------- small instance: half adder {a&b, a^b} ----------------
    // Half-adder table packed v3..v0 = 10,01,01,00 -> 8'h94.
    logic        start_small = 1'b0;
    logic [1:0]  s_in;
    logic [1:0]  s_out;
    logic        s_busy, s_done, s_pass, s_fev;
    logic [2:0]  s_err;
    logic [1:0]  s_fvec;
    logic [7:0]  s_tt;
    logic [1:0]  s_st;

    assign s_out = {s_in[1] & s_in[0], s_in[1] ^ s_in[0]};

    exhaustive_sweep_checker #(
        .N_IN(2), .N_OUT(2), .DWELL(1), .EXP_TT(8'h94), .DC_MASK(4'h0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_small),
        .dut_in(s_in), .dut_out(s_out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
        .first_err_valid(s_fev), .first_err_vec(s_fvec),
        .tt_captured(s_tt), .state_dbg(s_st)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] v;
        if (exp_q.size() == 0) begin
            v = 32'hDEAD_BEEF;
        end else begin
            v = exp_q.pop_front();
        end
        return v;
    endfunction

    // Reference model for the 4-input instances: parity or stuck-at-0 target
    // checked against a parity expectation with a don't-care mask.
    function automatic void model4(input bit stuck, input logic [15:0] mask,
                                   output int errs, output int fvalid,
                                   output int fvec, output logic [15:0] tt);
        logic [15:0] exp_tt;
        logic [3:0]  vb;
        logic        o;
        exp_tt = 16'h6996;
        errs = 0; fvalid = 0; fvec = 0; tt = '0;
        for (int v = 0; v < 16; v++) begin
            vb = v[3:0];
            o  = stuck ? 1'b0 : (vb[3] ^ vb[2] ^ vb[1] ^ vb[0]);
            tt[v] = o;
            if (!mask[v] && (o != exp_tt[v])) begin
                errs++;
                if (fvalid == 0) begin
                    fvalid = 1;
                    fvec   = v;
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_small();
        logic [7:0] tt;
        logic [1:0] vb;
        tt = '0;
        for (int v = 0; v < 4; v++) begin
            vb = v[1:0];
            tt[v*2 +: 2] = {vb[1] & vb[0], vb[1] ^ vb[0]};
        end
        return tt;
    endfunction

    // ---------------- driver: full sweep on the main instance ----------------
    // Pushes the expected vector sequence and final results when start is
    // driven, then pops them as the DUT presents each vector and finishes.
    task automatic run_main(input bit stuck, input bit poke_start);
        int errs, fva, fve;
        logic [15:0] tt;
        int p0, p1;
        mode_stuck = stuck;
        model4(stuck, 16'h0000, errs, fva, fve, tt);
        p0 = $urandom_range(20, 70);
        p1 = $urandom_range(90, 150);
        @(negedge clk);
        start_main = 1'b1;
        for (int v = 0; v < 16; v++) exp_q.push_back(32'(v));
        exp_q.push_back(32'(errs));
        exp_q.push_back(32'(fva));
        exp_q.push_back(32'(fve));
        exp_q.push_back({16'h0, tt});
        exp_q.push_back((errs == 0) ? 32'd1 : 32'd0);
        @(posedge clk);                      // start edge k
        for (int cyc = 0; cyc < 160; cyc++) begin
            @(negedge clk);                  // after edge k+cyc
            start_main = poke_start && (cyc == p0 || cyc == p0 + 1 || cyc == p1);
            if (cyc % 10 == 9) begin
                check("dut_in", {28'h0, m_in}, pop_exp());
                check("busy", {31'h0, m_busy}, 32'd1);
            end
        end
        start_main = 1'b0;
        check("done_early", {31'h0, m_done}, 32'd0);
        @(negedge clk);                      // after edge k+160
        check("done", {31'h0, m_done}, 32'd1);
        check("busy_off", {31'h0, m_busy}, 32'd0);
        check("dut_in_done", {28'h0, m_in}, 32'd0);
        check("state_done", {30'h0, m_st}, 32'd2);
        check("err_cnt", {27'h0, m_err}, pop_exp());
        check("fev_valid", {31'h0, m_fev}, pop_exp());
        check("fev_vec", {28'h0, m_fvec}, pop_exp());
        check("tt", {16'h0, m_tt}, pop_exp());
        check("pass", {31'h0, m_pass}, pop_exp());
        check("q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int errs, fva, fve;
        logic [15:0] tt;
        logic [7:0]  stt;
        int guard;

        // 1: reset with arbitrary start
        start_main  = 1'($urandom_range(0, 1));
        start_small = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, m_busy}, 32'd0);
        check("rst_done", {31'h0, m_done}, 32'd0);
        check("rst_pass", {31'h0, m_pass}, 32'd0);
        check("rst_err", {27'h0, m_err}, 32'd0);
        check("rst_dut_in", {28'h0, m_in}, 32'd0);
        check("rst_tt", {16'h0, m_tt}, 32'd0);
        check("rst_small_tt", {24'h0, s_tt}, 32'd0);
        start_main  = 1'b0;
        start_small = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", {30'h0, m_st}, 32'd0);

        // 2: parity target, expect pass
        run_main(1'b0, 1'b0);

        // 3 + 4: stuck-at-0 target; masked instance ran the same sweep
        run_main(1'b1, 1'b0);
        model4(1'b1, 16'h0006, errs, fva, fve, tt);
        check("dc_done", {31'h0, d_done}, 32'd1);
        check("dc_err", {27'h0, d_err}, 32'(errs));
        check("dc_fev_vec", {28'h0, d_fvec}, 32'(fve));
        check("dc_fev_valid", {31'h0, d_fev}, 32'(fva));
        check("dc_tt", {16'h0, d_tt}, {16'h0, tt});
        check("dc_pass", {31'h0, d_pass}, 32'd0);

        // 5: reset mid-sweep at dut_in=5 (stuck target: v1,v2,v4 have failed)
        mode_stuck = 1'b1;
        @(negedge clk); start_main = 1'b1;
        @(negedge clk); start_main = 1'b0;
        guard = 0;
        while (m_in != 4'd5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_vec5", 32'(guard < 200), 32'd1);
        check("mid_err", {27'h0, m_err}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, m_busy}, 32'd0);
        check("abort_err", {27'h0, m_err}, 32'd0);
        check("abort_dut_in", {28'h0, m_in}, 32'd0);
        check("abort_fev", {31'h0, m_fev}, 32'd0);
        check("abort_state", {30'h0, m_st}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_main(1'b0, 1'b1);

        // 6: half adder, DWELL=1, then restart from DONE
        stt = model_small();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk); start_small = 1'b1;
            @(posedge clk);                  // start edge k
            @(negedge clk); start_small = 1'b0;
            check("sm_busy", {31'h0, s_busy}, 32'd1);
            check("sm_cleared_tt", {24'h0, s_tt}, 32'd0);
            check("sm_cleared_err", {29'h0, s_err}, 32'd0);
            repeat (3) @(negedge clk);       // after edge k+3
            check("sm_done_early", {31'h0, s_done}, 32'd0);
            @(negedge clk);                  // after edge k+4
            check("sm_done", {31'h0, s_done}, 32'd1);
            check("sm_tt", {24'h0, s_tt}, {24'h0, stt});
            check("sm_pass", {31'h0, s_pass}, (stt == 8'h94) ? 32'd1 : 32'd0);
            check("sm_err", {29'h0, s_err}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
